alu_seq_ctrl: RTL and testbench

Sequencing stage that sits directly upstream of the 16-bit two-operand ALU (op[1:0], i0, i1 -> o, cout).
- Holds a small register file and accepts 3-address instructions over a valid/ready handshake.
- Presents the operation and operand registers to the ALU, then writes the ALU result and carry back into the register file.
- Also provides a load port and a read port so the surrounding logic or bench can initialise and inspect registers.

---
 rtl/alu_seq_pkg.sv | 19 +
 rtl/alu_seq_ctrl_if.sv | 32 +++
 rtl/alu_seq_regfile.sv | 48 ++++
 rtl/alu_seq_ctrl.sv | 67 ++++++
 tb/tb_alu_seq_ctrl.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared op codes, FSM encoding, default sizes and instruction field offsets
package alu_seq_pkg;
    localparam int DEF_WIDTH = 16;
    localparam int DEF_NREGS = 8;
    localparam int DEF_AW    = 3;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_OR  = 2'b11;

    // Field positions in units of AW: instr = {op, rd, rs1, rs2}
    localparam int RS2_POS = 0;
    localparam int RS1_POS = 1;
    localparam int RD_POS  = 2;
    localparam int OP_POS  = 3;

    typedef enum logic {ST_IDLE, ST_EXEC} state_t;
endpackage

// File: rtl/alu_seq_ctrl_if.sv
// alu_seq_ctrl_if: instruction handshake, ALU bus, load/read ports and status of alu_seq_ctrl
//   master: surrounding logic (issues instructions, hosts the ALU, loads/inspects registers)
//   slave : alu_seq_ctrl
interface alu_seq_ctrl_if import alu_seq_pkg::*; #(
    parameter int WIDTH = DEF_WIDTH,
    parameter int AW    = DEF_AW
) ();
    logic              instr_valid;
    logic              instr_ready;
    logic [2+3*AW-1:0] instr;
    logic [1:0]        alu_op;
    logic [WIDTH-1:0]  alu_i0;
    logic [WIDTH-1:0]  alu_i1;
    logic [WIDTH-1:0]  alu_o;
    logic              alu_cout;
    logic              ld_valid;
    logic [AW-1:0]     ld_addr;
    logic [WIDTH-1:0]  ld_data;
    logic [AW-1:0]     rd_addr;
    logic [WIDTH-1:0]  rd_data;
    logic              carry_flag;
    logic              done;

    modport master (
        output instr_valid, instr, alu_o, alu_cout, ld_valid, ld_addr, ld_data, rd_addr,
        input  instr_ready, alu_op, alu_i0, alu_i1, rd_data, carry_flag, done
    );
    modport slave (
        input  instr_valid, instr, alu_o, alu_cout, ld_valid, ld_addr, ld_data, rd_addr,
        output instr_ready, alu_op, alu_i0, alu_i1, rd_data, carry_flag, done
    );
endinterface

// File: rtl/alu_seq_regfile.sv
// alu_seq_regfile: NREGS x WIDTH register file, three combinational reads, load and writeback ports
//   clk, reset          : clock, async active-high reset (clears all registers)
//   ra0/ra1/ra2, rdata* : combinational read ports (operands and inspect)
//   ld_en/addr/data     : external load port
//   wb_en/addr/data     : writeback port, wins over a load to the same address
//   Macro ALU_SEQ_R0_ZERO_EN: register 0 reads as zero and ignores writes
module alu_seq_regfile import alu_seq_pkg::*; #(
    parameter int WIDTH = DEF_WIDTH,
    parameter int NREGS = DEF_NREGS,
    parameter int AW    = DEF_AW
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [AW-1:0]    ra0,
    input  logic [AW-1:0]    ra1,
    input  logic [AW-1:0]    ra2,
    output logic [WIDTH-1:0] rdata0,
    output logic [WIDTH-1:0] rdata1,
    output logic [WIDTH-1:0] rdata2,
    input  logic             ld_en,
    input  logic [AW-1:0]    ld_addr,
    input  logic [WIDTH-1:0] ld_data,
    input  logic             wb_en,
    input  logic [AW-1:0]    wb_addr,
    input  logic [WIDTH-1:0] wb_data
);
`ifdef ALU_SEQ_R0_ZERO_EN
    localparam bit R0_ZERO = 1'b1;
`else
    localparam bit R0_ZERO = 1'b0;
`endif

    logic [WIDTH-1:0] rf [NREGS];

    assign rdata0 = (R0_ZERO && ra0 == '0) ? '0 : rf[ra0];
    assign rdata1 = (R0_ZERO && ra1 == '0) ? '0 : rf[ra1];
    assign rdata2 = (R0_ZERO && ra2 == '0) ? '0 : rf[ra2];

    // Writeback is assigned last so it overrides a same-address load
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rf <= '{default: '0};
        end else begin
            if (ld_en && !(R0_ZERO && ld_addr == '0)) rf[ld_addr] <= ld_data;
            if (wb_en && !(R0_ZERO && wb_addr == '0)) rf[wb_addr] <= wb_data;
        end
    end
endmodule

// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: two-state sequencer feeding a combinational ALU and writing its result back
//   clk, reset : clock, async active-high reset
//   bus        : alu_seq_ctrl_if.slave (instr handshake, ALU op/operands/result, load, read, carry_flag, done)
//   Macro ALU_SEQ_R0_ZERO_EN (handled in alu_seq_regfile): register 0 hardwired to zero
module alu_seq_ctrl import alu_seq_pkg::*; #(
    parameter int WIDTH = DEF_WIDTH,
    parameter int NREGS = DEF_NREGS,
    parameter int AW    = DEF_AW
) (
    input logic           clk,
    input logic           reset,
    alu_seq_ctrl_if.slave bus
);
    state_t           state, state_nx;
    logic             accept;
    logic [AW-1:0]    rd_q;
    logic [WIDTH-1:0] rs1_val, rs2_val;

    alu_seq_regfile #(.WIDTH(WIDTH), .NREGS(NREGS), .AW(AW)) u_rf (
        .clk     (clk),
        .reset   (reset),
        .ra0     (bus.instr[RS1_POS*AW +: AW]),
        .ra1     (bus.instr[RS2_POS*AW +: AW]),
        .ra2     (bus.rd_addr),
        .rdata0  (rs1_val),
        .rdata1  (rs2_val),
        .rdata2  (bus.rd_data),
        .ld_en   (bus.ld_valid),
        .ld_addr (bus.ld_addr),
        .ld_data (bus.ld_data),
        .wb_en   (state == ST_EXEC),
        .wb_addr (rd_q),
        .wb_data (bus.alu_o)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nx;
    end

    // EXEC always lasts one cycle, so the next state is EXEC only on acceptance
    always_comb begin
        bus.instr_ready = (state == ST_IDLE);
        accept          = bus.instr_ready && bus.instr_valid;
        state_nx        = accept ? ST_EXEC : ST_IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.alu_op     <= '0;
            bus.alu_i0     <= '0;
            bus.alu_i1     <= '0;
            bus.carry_flag <= 1'b0;
            bus.done       <= 1'b0;
            rd_q           <= '0;
        end else begin
            bus.done <= (state == ST_EXEC);
            if (state == ST_EXEC) bus.carry_flag <= bus.alu_cout;
            if (accept) begin
                bus.alu_op <= bus.instr[OP_POS*AW +: 2];
                bus.alu_i0 <= rs1_val;
                bus.alu_i1 <= rs2_val;
                rd_q       <= bus.instr[RD_POS*AW +: AW];
            end
        end
    end
endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb_alu_seq_ctrl: directed self-checking bench for alu_seq_ctrl with a behavioural 16-bit ALU
module tb_alu_seq_ctrl;
    import alu_seq_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_tests = 0;
    int   n_fail = 0;
    logic [16:0] alu_sum;

    alu_seq_ctrl_if bus ();
    alu_seq_ctrl dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    // ALU: SUB computes i0 + ~i1 + 1, carry out is the no-borrow bit; logic ops give carry 0
    always_comb begin
        alu_sum = (bus.alu_op == OP_SUB) ? {1'b0, bus.alu_i0} + {1'b0, ~bus.alu_i1} + 17'd1
                                         : {1'b0, bus.alu_i0} + {1'b0, bus.alu_i1};
        bus.alu_o    = (bus.alu_op == OP_AND) ? (bus.alu_i0 & bus.alu_i1) :
                       (bus.alu_op == OP_OR)  ? (bus.alu_i0 | bus.alu_i1) : alu_sum[15:0];
        bus.alu_cout = bus.alu_op[1] ? 1'b0 : alu_sum[16];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [2:0] a, input logic [15:0] d);
        bus.ld_valid = 1'b1;
        bus.ld_addr  = a;
        bus.ld_data  = d;
        tick();
        bus.ld_valid = 1'b0;
    endtask

    task automatic chk_reg(input string tag, input logic [2:0] a, input logic [15:0] exp);
        bus.rd_addr = a;
        #1;
        check(tag, bus.rd_data, exp);
    endtask

    // Offers an instruction, waits (bounded) for acceptance, returns one cycle later in EXEC
    task automatic issue(input logic [1:0] op, input logic [2:0] rd, input logic [2:0] rs1, input logic [2:0] rs2);
        bus.instr       = {op, rd, rs1, rs2};
        bus.instr_valid = 1'b1;
        for (int i = 0; i < 8 && !bus.instr_ready; i++) tick();
        check("ready_before_accept", bus.instr_ready, 1);
        tick();
        bus.instr_valid = 1'b0;
    endtask

    task automatic run(input logic [1:0] op, input logic [2:0] rd, input logic [2:0] rs1, input logic [2:0] rs2,
                       input logic [15:0] exp_i0, input logic [15:0] exp_i1);
        issue(op, rd, rs1, rs2);
        check("alu_op", bus.alu_op, op);
        check("alu_i0", bus.alu_i0, exp_i0);
        check("alu_i1", bus.alu_i1, exp_i1);
        check("done_in_exec", bus.done, 0);
        check("ready_in_exec", bus.instr_ready, 0);
        tick();
        check("done_after_wb", bus.done, 1);
    endtask

    initial begin
        bus.instr_valid = 1'b0;
        bus.instr       = '0;
        bus.ld_valid    = 1'b0;
        bus.ld_addr     = '0;
        bus.ld_data     = '0;
        bus.rd_addr     = '0;
        #2;
        check("rst_ready", bus.instr_ready, 1);
        check("rst_done", bus.done, 0);
        check("rst_carry", bus.carry_flag, 0);
        check("rst_alu", {bus.alu_op, bus.alu_i0, bus.alu_i1}, 0);
        chk_reg("rst_r7", 3'd7, 16'h0000);
        @(negedge clk);
        reset = 1'b0;
        tick();

        // 1: ADD r3 = r1 + r2
        load(3'd1, 16'haa55);
        load(3'd2, 16'h55aa);
        run(OP_ADD, 3'd3, 3'd1, 3'd2, 16'haa55, 16'h55aa);
        chk_reg("add_r3", 3'd3, 16'hffff);
        check("add_carry", bus.carry_flag, 0);
        tick();
        check("done_one_cycle", bus.done, 0);

        // 2: ADD with carry out
        load(3'd4, 16'hffff);
        load(3'd5, 16'h0001);
        run(OP_ADD, 3'd6, 3'd4, 3'd5, 16'hffff, 16'h0001);
        chk_reg("add_wrap_r6", 3'd6, 16'h0000);
        check("add_wrap_carry", bus.carry_flag, 1);

        // 3: SUB, AND, OR
        run(OP_SUB, 3'd7, 3'd1, 3'd2, 16'haa55, 16'h55aa);
        chk_reg("sub_r7", 3'd7, 16'h54ab);
        check("sub_carry", bus.carry_flag, 1);
        run(OP_AND, 3'd3, 3'd1, 3'd2, 16'haa55, 16'h55aa);
        chk_reg("and_r3", 3'd3, 16'h0000);
        check("and_carry", bus.carry_flag, 0);
        run(OP_OR, 3'd3, 3'd1, 3'd2, 16'haa55, 16'h55aa);
        chk_reg("or_r3", 3'd3, 16'hffff);

        // 4: back-to-back dependent instructions with valid held high
        bus.instr       = {OP_OR, 3'd3, 3'd1, 3'd2};
        bus.instr_valid = 1'b1;
        tick();
        bus.instr = {OP_ADD, 3'd4, 3'd3, 3'd3};
        check("b2b_busy", bus.instr_ready, 0);
        tick();
        check("b2b_first_done", bus.done, 1);
        check("b2b_ready_again", bus.instr_ready, 1);
        tick();
        bus.instr_valid = 1'b0;
        check("b2b_second_i0", bus.alu_i0, 16'hffff);
        check("b2b_second_i1", bus.alu_i1, 16'hffff);
        tick();
        check("b2b_second_done", bus.done, 1);
        chk_reg("b2b_r4", 3'd4, 16'hfffe);
        check("b2b_carry", bus.carry_flag, 1);

        // 5a: reset during EXEC suppresses the writeback
        issue(OP_ADD, 3'd0, 3'd1, 3'd2);
        reset = 1'b1;
        #1;
        check("exec_rst_done", bus.done, 0);
        check("exec_rst_i0", bus.alu_i0, 0);
        tick();
        check("exec_rst_done_held", bus.done, 0);
        @(negedge clk);
        reset = 1'b0;
        check("post_rst_ready", bus.instr_ready, 1);
        for (int a = 0; a < 8; a++) chk_reg($sformatf("post_rst_r%0d", a), a[2:0], 16'h0000);
        tick();
        check("post_rst_done", bus.done, 0);

        // 5b: load colliding with writeback to the same register, then to a different one
        load(3'd1, 16'haa55);
        load(3'd2, 16'h55aa);
        issue(OP_ADD, 3'd3, 3'd1, 3'd2);
        bus.ld_valid = 1'b1;
        bus.ld_addr  = 3'd3;
        bus.ld_data  = 16'h1234;
        tick();
        bus.ld_valid = 1'b0;
        chk_reg("wb_wins_r3", 3'd3, 16'hffff);
        issue(OP_ADD, 3'd6, 3'd1, 3'd2);
        bus.ld_valid = 1'b1;
        bus.ld_addr  = 3'd5;
        bus.ld_data  = 16'h0bad;
        tick();
        bus.ld_valid = 1'b0;
        chk_reg("both_commit_r6", 3'd6, 16'hffff);
        chk_reg("both_commit_r5", 3'd5, 16'h0bad);

        // 5c: load to an operand during EXEC does not disturb the in-flight op
        issue(OP_SUB, 3'd7, 3'd2, 3'd1);
        bus.ld_valid = 1'b1;
        bus.ld_addr  = 3'd1;
        bus.ld_data  = 16'h0000;
        tick();
        bus.ld_valid = 1'b0;
        chk_reg("inflight_r7", 3'd7, 16'hab55);
        check("inflight_carry", bus.carry_flag, 0);
        load(3'd1, 16'haa55);

        // 6: register 0 behaviour
        load(3'd0, 16'h1234);
`ifdef ALU_SEQ_R0_ZERO_EN
        chk_reg("r0_load", 3'd0, 16'h0000);
        run(OP_ADD, 3'd0, 3'd1, 3'd2, 16'haa55, 16'h55aa);
        chk_reg("r0_wb", 3'd0, 16'h0000);
`else
        chk_reg("r0_load", 3'd0, 16'h1234);
        run(OP_ADD, 3'd0, 3'd1, 3'd2, 16'haa55, 16'h55aa);
        chk_reg("r0_wb", 3'd0, 16'hffff);
`endif
        check("r0_carry", bus.carry_flag, 0);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
